// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// The producer drives tx_data/tx_valid; the transmitter returns tx_ready.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd when PARITY_ODD=1).
module uart_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  s,
    output logic      tx,
    output logic      busy
);
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int STOP_LEN = STOP_BITS * DIV;
    localparam int CW       = $clog2(STOP_LEN);
    localparam int BW       = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_LEN - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic par, par_n;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_idx, bit_n;
    logic [DATA_BITS-1:0] shifter, sh_n;
    logic [DATA_BITS-1:0] hold, hold_n;
    logic                 hold_full, hold_full_n;
    logic                 tx_n;
    logic                 load;

    assign s.tx_ready = !hold_full;
    assign busy       = (state != IDLE) || hold_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shifter   <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            tx        <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_n;
            shifter   <= sh_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            tx        <= tx_n;
`ifdef UART_TX_PARITY_EN
            par       <= par_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt + 1'b1;
        bit_n       = bit_idx;
        sh_n        = shifter;
        hold_n      = hold;
        hold_full_n = hold_full;
        tx_n        = tx;
        load        = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n       = par;
`endif
        // Accept and load are mutually exclusive: accept needs an empty holding reg, load a full one.
        if (s.tx_valid && !hold_full) begin
            hold_n      = s.tx_data;
            hold_full_n = 1'b1;
        end

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (hold_full) begin
                    load    = 1'b1;
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (cnt == BIT_END) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = DATA;
                    tx_n    = shifter[0];
                end
            end
            DATA: begin
                if (cnt == BIT_END) begin
                    cnt_n = '0;
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        tx_n    = par;
`else
                        state_n = STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        sh_n  = shifter >> 1;
                        tx_n  = sh_n[0];
                        bit_n = bit_idx + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (cnt == BIT_END) begin
                    cnt_n   = '0;
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt == STOP_END) begin
                    cnt_n = '0;
                    // A pending byte starts its start bit on this same edge: no idle gap.
                    if (hold_full) begin
                        load    = 1'b1;
                        state_n = START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase

        if (load) begin
            sh_n        = hold;
            hold_full_n = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_n       = (^hold) ^ 1'(PARITY_ODD);
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Randomised bench for uart_tx: two instances (8N1 even, 5-bit/2-stop odd) checked every
// cycle against a frame-timeline model built from accept times and frame lengths.
module tb_uart_tx;
    localparam int DIV  = 4;
    localparam int MAXF = 128;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_a, busy_a, tx_b, busy_b;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uart_tx_if #(.DATA_BITS(8)) ifa ();
    uart_tx_if #(.DATA_BITS(5)) ifb ();

    uart_tx #(.CLK_FREQ(16), .BAUD(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_a (
        .clk(clk), .rst(rst), .s(ifa), .tx(tx_a), .busy(busy_a));
    uart_tx #(.CLK_FREQ(16), .BAUD(4), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(1)) u_b (
        .clk(clk), .rst(rst), .s(ifb), .tx(tx_b), .busy(busy_b));

    // Per instance: accept edge, first start-bit edge and data of every accepted byte.
    int         acc_t [2][MAXF];
    int         st_t  [2][MAXF];
    logic [7:0] dat   [2][MAXF];
    int         nfr   [2];
    int         base  [2];

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int nb(input int id);
        return (id != 0) ? 5 : 8;
    endfunction

    function automatic int flen(input int id);
        return (1 + nb(id) + P + ((id != 0) ? 2 : 1)) * DIV;
    endfunction

    function automatic logic frame_bit(input int id, input logic [7:0] d, input int pos);
        if (pos == 0) return 1'b0;
        if (pos <= nb(id)) return d[pos-1];
        if (P == 1 && pos == nb(id) + 1) return (^d) ^ ((id != 0) ? 1'b1 : 1'b0);
        return 1'b1;
    endfunction

    function automatic logic m_tx(input int id, input int k);
        for (int f = base[id]; f < nfr[id]; f++)
            if (k >= st_t[id][f] && k < st_t[id][f] + flen(id))
                return frame_bit(id, dat[id][f], (k - st_t[id][f]) / DIV);
        return 1'b1;
    endfunction

    function automatic logic m_busy(input int id, input int k);
        for (int f = base[id]; f < nfr[id]; f++)
            if (k >= acc_t[id][f] && k < st_t[id][f] + flen(id)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_ready(input int id, input int k);
        for (int f = base[id]; f < nfr[id]; f++)
            if (k >= acc_t[id][f] && k < st_t[id][f]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_all();
        chk($sformatf("tx0@%0d", cyc),   tx_a,         m_tx(0, cyc));
        chk($sformatf("busy0@%0d", cyc), busy_a,       m_busy(0, cyc));
        chk($sformatf("rdy0@%0d", cyc),  ifa.tx_ready, m_ready(0, cyc));
        chk($sformatf("tx1@%0d", cyc),   tx_b,         m_tx(1, cyc));
        chk($sformatf("busy1@%0d", cyc), busy_b,       m_busy(1, cyc));
        chk($sformatf("rdy1@%0d", cyc),  ifb.tx_ready, m_ready(1, cyc));
    endtask

    // Called just after a negedge: check outputs, drive one instance, advance one cycle.
    task automatic tick(input int id, input bit v, input logic [7:0] d, output bit took);
        int n, last_end, s;
        check_all();
        took = 1'b0;
        ifa.tx_valid = (id == 0) && v;
        ifb.tx_valid = (id == 1) && v;
        if (id == 0) ifa.tx_data = d;
        else         ifb.tx_data = d[4:0];
        if (v && m_ready(id, cyc) && nfr[id] < MAXF) begin
            n        = nfr[id];
            last_end = (n > base[id]) ? st_t[id][n-1] + flen(id) : 0;
            s        = (cyc + 2 > last_end) ? cyc + 2 : last_end;
            acc_t[id][n] = cyc + 1;
            st_t[id][n]  = s;
            dat[id][n]   = (id != 0) ? {3'b000, d[4:0]} : d;
            nfr[id]      = n + 1;
            took         = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int id, input int n);
        bit t;
        for (int i = 0; i < n; i++) tick(id, 1'b0, 8'h00, t);
    endtask

    task automatic send_wait(input int id, input logic [7:0] d);
        bit t;
        int n;
        t = 1'b0;
        n = 0;
        while (!t && n < 200) begin
            tick(id, 1'b1, d, t);
            n++;
        end
        if (!t) chk("accept_timeout", 0, 1);
    endtask

    initial begin
        bit t;
        int s;
        logic [7:0] three [3];
        three[0] = 8'h12; three[1] = 8'hC3; three[2] = 8'h7E;
        nfr[0] = 0; nfr[1] = 0; base[0] = 0; base[1] = 0;
        ifa.tx_valid = 1'b0; ifa.tx_data = '0;
        ifb.tx_valid = 1'b0; ifb.tx_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx0", tx_a, 1);    chk("rst_rdy0", ifa.tx_ready, 1); chk("rst_busy0", busy_a, 0);
        chk("rst_tx1", tx_b, 1);    chk("rst_rdy1", ifb.tx_ready, 1); chk("rst_busy1", busy_b, 0);
        rst = 1'b0;

        // Single frame, then two frames with the second offered mid-frame.
        tick(0, 1'b1, 8'hA5, t);
        idle(0, 50);
        tick(0, 1'b1, 8'h00, t);
        idle(0, 4);
        tick(0, 1'b1, 8'hFF, t);
        idle(0, 90);

        // Three bytes offered back-to-back; the third waits for the holding reg.
        for (int i = 0; i < 3; i++) send_wait(0, three[i]);
        idle(0, 140);

        // Reset during data bit 3 of 0x3C, then a clean 0x81 frame.
        tick(0, 1'b1, 8'h3C, t);
        s = st_t[0][nfr[0]-1];
        while (cyc < s + 4 * DIV + 1) tick(0, 1'b0, 8'h00, t);
        rst = 1'b1;
        #1;
        chk("midrst_tx0", tx_a, 1);
        chk("midrst_rdy0", ifa.tx_ready, 1);
        chk("midrst_busy0", busy_a, 0);
        @(negedge clk);
        rst = 1'b0;
        base[0] = nfr[0];
        base[1] = nfr[1];
        tick(0, 1'b1, 8'h81, t);
        idle(0, 45);

        // Parity corner byte, then random traffic including ignored valid-while-full.
        tick(0, 1'b1, 8'h07, t);
        idle(0, 50);
        for (int i = 0; i < 400; i++) tick(0, ($urandom_range(0, 3) == 0), 8'($urandom), t);
        idle(0, 100);

        // 5-bit / 2-stop / odd instance.
        tick(1, 1'b1, 8'h1F, t);
        idle(1, 40);
        tick(1, 1'b1, 8'h07, t);
        idle(1, 40);
        for (int i = 0; i < 400; i++) tick(1, ($urandom_range(0, 2) == 0), 8'($urandom), t);
        idle(1, 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
